// File: rtl/pixel_layer_mixer_pkg.sv
// Shared definitions for the pixel layer mixer.
//   NLAYERS / PIXW : layer count and bits per layer pixel (value 0 = transparent)
//   CNTW           : width of each per-hazard overlap counter
//   CDW            : width of the post-fail cooldown frame counter
//   FCW            : width of the fail event counter
//   fsm_state_e    : fail handshake states
package pixel_layer_mixer_pkg;

    localparam int NLAYERS = 4;
    localparam int PIXW    = 4;
    localparam int CNTW    = 8;
    localparam int CDW     = 8;
    localparam int FCW     = 8;

    typedef enum logic [1:0] {
        ARMED    = 2'd0,
        FAILED   = 2'd1,
        COOLDOWN = 2'd2
    } fsm_state_e;

    function automatic logic [FCW-1:0] sat_inc_fc(input logic [FCW-1:0] v);
        return (v == '1) ? v : v + FCW'(1);
    endfunction

endpackage

// File: rtl/pixel_layer_mixer_if.sv
// Pixel and fail-handshake bundle between the pixel generators / game core
// and the layer mixer.
//   pix_en, frame_start, layer_pix : pixel stream into the mixer
//   fail_enable, fail_ack          : game core control of the fail request
//   pix_out, pix_out_valid         : composited pixel towards vga_bitchange
//   collision_vec, fail_req,
//   fail_count                     : collision status towards the game core
// master = source side (generators + core), slave = the mixer.
interface pixel_layer_mixer_if;
    import pixel_layer_mixer_pkg::*;

    logic                    pix_en;
    logic                    frame_start;
    logic [NLAYERS*PIXW-1:0] layer_pix;
    logic                    fail_enable;
    logic                    fail_ack;
    logic [PIXW-1:0]         pix_out;
    logic                    pix_out_valid;
    logic [NLAYERS-1:0]      collision_vec;
    logic                    fail_req;
    logic [FCW-1:0]          fail_count;

    modport master (
        output pix_en, frame_start, layer_pix, fail_enable, fail_ack,
        input  pix_out, pix_out_valid, collision_vec, fail_req, fail_count
    );

    modport slave (
        input  pix_en, frame_start, layer_pix, fail_enable, fail_ack,
        output pix_out, pix_out_valid, collision_vec, fail_req, fail_count
    );

endinterface

// File: rtl/pixel_layer_mixer_overlap_counter.sv
// Per-hazard overlap counter.
//   clk, rst   : clock, asynchronous active-high reset
//   inc        : count one overlap pixel (saturates at all-ones)
//   clear_load : frame boundary; count is replaced by load_val (inc ignored)
//   load_val   : value for the first pixel of the new frame (0 or 1)
//   threshold  : overlap count that constitutes a collision
//   count, hit : current count, count >= threshold
module pixel_layer_mixer_overlap_counter
    import pixel_layer_mixer_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            inc,
    input  logic            clear_load,
    input  logic [CNTW-1:0] load_val,
    input  logic [CNTW-1:0] threshold,
    output logic [CNTW-1:0] count,
    output logic            hit
);

    logic [CNTW-1:0] count_d, count_q;

    always_comb begin
        count_d = count_q;
        if (clear_load) begin
            count_d = load_val;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + CNTW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign hit   = (count_q >= threshold);

endmodule

// File: rtl/pixel_layer_mixer.sv
// N-layer pixel compositor with per-frame hazard collision detection and a
// held fail request.
//   board_clk : clock
//   Reset     : asynchronous, active-high
//   bus       : pixel_layer_mixer_if.slave (pixel stream in, composited
//               pixel and collision / fail status out)
// Two-stage pipeline: S1 registers the inputs, S2 registers pix_out and the
// collision/fail state computed from S1 data.
//
// FSM states:
//   state    | meaning
//   ARMED    | a frame with a collision (and fail_enable) raises fail_req
//   FAILED   | fail_req held until fail_ack
//   COOLDOWN | collisions ignored for COOLDOWN_FR frame boundaries
module pixel_layer_mixer
    import pixel_layer_mixer_pkg::*;
#(
    parameter int                 PLAYER_IDX   = 0,
    parameter logic [NLAYERS-1:0] HAZARD_MASK  = 4'b0100,
    parameter logic [NLAYERS-1:0] OVERLAY_MASK = 4'b0010,
    parameter logic [PIXW-1:0]    BG_IDX       = '0,
    parameter int                 MIN_OVERLAP  = 4,
    parameter int                 COOLDOWN_FR  = 30
) (
    input logic                board_clk,
    input logic                Reset,
    pixel_layer_mixer_if.slave bus
);

    // lowest-index opaque priority layer wins; overlay layers are ORed on top
    function automatic logic [PIXW-1:0] compose(input logic [NLAYERS*PIXW-1:0] layers);
        logic [PIXW-1:0] prio;
        logic [PIXW-1:0] ovl;
        logic [PIXW-1:0] p;
        prio = BG_IDX;
        ovl  = '0;
        for (int i = NLAYERS - 1; i >= 0; i--) begin
            p = layers[i*PIXW +: PIXW];
            if (OVERLAY_MASK[i]) begin
                ovl = ovl | p;
            end else if (p != '0) begin
                prio = p;
            end
        end
        return prio | ovl;
    endfunction

    logic                    pix_en_s1_d, pix_en_s1_q;
    logic                    frame_start_s1_d, frame_start_s1_q;
    logic [NLAYERS*PIXW-1:0] layer_s1_d, layer_s1_q;

    logic [PIXW-1:0]         pix_out_d, pix_out_q;
    logic                    pix_out_valid_d, pix_out_valid_q;
    logic [NLAYERS-1:0]      collision_vec_d, collision_vec_q;
    logic                    fail_req_d, fail_req_q;
    logic [FCW-1:0]          fail_count_d, fail_count_q;
    logic [CDW-1:0]          cooldown_d, cooldown_q;
    fsm_state_e              state_d, state_q;

    logic [PIXW-1:0]         player_pix;
    logic [NLAYERS-1:0]      hazard_hit;
    logic [CNTW-1:0]         hazard_cnt [NLAYERS];
    logic                    unused_cnt;

    always_comb begin
        pix_en_s1_d      = bus.pix_en;
        frame_start_s1_d = bus.frame_start;
        layer_s1_d       = bus.layer_pix;
    end

    assign player_pix = layer_s1_q[PLAYER_IDX*PIXW +: PIXW];

    // The player layer never collides with itself, whatever HAZARD_MASK says.
    for (genvar h = 0; h < NLAYERS; h++) begin : g_layer
        if (HAZARD_MASK[h] && (h != PLAYER_IDX)) begin : g_hazard
            logic overlap;
            assign overlap = pix_en_s1_q && (player_pix != '0) &&
                             (layer_s1_q[h*PIXW +: PIXW] != '0);

            // The boundary pixel belongs to the new frame, hence load_val.
            pixel_layer_mixer_overlap_counter u_cnt (
                .clk        (board_clk),
                .rst        (Reset),
                .inc        (overlap),
                .clear_load (frame_start_s1_q),
                .load_val   ({{(CNTW-1){1'b0}}, overlap}),
                .threshold  (CNTW'(MIN_OVERLAP)),
                .count      (hazard_cnt[h]),
                .hit        (hazard_hit[h])
            );
        end else begin : g_none
            assign hazard_cnt[h] = '0;
            assign hazard_hit[h] = 1'b0;
        end
    end

    // Raw counts are not exported; folded here to keep them visible for probing.
    always_comb begin
        unused_cnt = 1'b0;
        for (int i = 0; i < NLAYERS; i++) begin
            unused_cnt = unused_cnt ^ (^hazard_cnt[i]);
        end
    end

    always_comb begin
        pix_out_d       = pix_en_s1_q ? compose(layer_s1_q) : '0;
        pix_out_valid_d = pix_en_s1_q;
        // hit reflects the finished frame: the counter clears on this same edge
        collision_vec_d = frame_start_s1_q ? hazard_hit : collision_vec_q;
    end

    always_comb begin
        state_d      = state_q;
        fail_req_d   = fail_req_q;
        fail_count_d = fail_count_q;
        cooldown_d   = cooldown_q;
        case (state_q)
            ARMED: begin
                if (frame_start_s1_q && (|collision_vec_d) && bus.fail_enable) begin
                    state_d      = FAILED;
                    fail_req_d   = 1'b1;
                    fail_count_d = sat_inc_fc(fail_count_q);
                end
            end
            FAILED: begin
                // ack wins over a coincident boundary; the boundary only latches collision_vec
                if (bus.fail_ack) begin
                    state_d    = COOLDOWN;
                    fail_req_d = 1'b0;
                    cooldown_d = CDW'(COOLDOWN_FR);
                end
            end
            COOLDOWN: begin
                if (cooldown_q == '0) begin
                    state_d = ARMED;
                end else if (frame_start_s1_q) begin
                    cooldown_d = cooldown_q - CDW'(1);
                end
            end
            default: begin
                state_d = ARMED;
            end
        endcase
    end

    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset) begin
            pix_en_s1_q      <= 1'b0;
            frame_start_s1_q <= 1'b0;
            layer_s1_q       <= '0;
            pix_out_q        <= '0;
            pix_out_valid_q  <= 1'b0;
            collision_vec_q  <= '0;
            fail_req_q       <= 1'b0;
            fail_count_q     <= '0;
            cooldown_q       <= '0;
            state_q          <= ARMED;
        end else begin
            pix_en_s1_q      <= pix_en_s1_d;
            frame_start_s1_q <= frame_start_s1_d;
            layer_s1_q       <= layer_s1_d;
            pix_out_q        <= pix_out_d;
            pix_out_valid_q  <= pix_out_valid_d;
            collision_vec_q  <= collision_vec_d;
            fail_req_q       <= fail_req_d;
            fail_count_q     <= fail_count_d;
            cooldown_q       <= cooldown_d;
            state_q          <= state_d;
        end
    end

    assign bus.pix_out       = pix_out_q;
    assign bus.pix_out_valid = pix_out_valid_q;
    assign bus.collision_vec = collision_vec_q;
    assign bus.fail_req      = fail_req_q;
    assign bus.fail_count    = fail_count_q;

endmodule

// File: tb/tb_pixel_layer_mixer.sv
// Testbench for pixel_layer_mixer: directed scenarios plus randomized traffic,
// all checked against a cycle-level reference model of the mixer's rules.
module tb_pixel_layer_mixer;
    import pixel_layer_mixer_pkg::*;

    localparam int         P_IDX = 0;
    localparam logic [3:0] HMASK = 4'b0100;
    localparam logic [3:0] OMASK = 4'b0010;
    localparam logic [3:0] BG    = 4'h9;
    localparam int         MINOV = 4;
    localparam int         CDFR  = 2;
    // player (layer 0) = 2 and hazard (layer 2) = 6 -> overlapping pixel
    localparam logic [15:0] OVP  = 16'h0602;
    localparam logic [15:0] PLY  = 16'h0002;

    logic board_clk;
    logic Reset;

    pixel_layer_mixer_if bus();

    pixel_layer_mixer #(
        .PLAYER_IDX   (P_IDX),
        .HAZARD_MASK  (HMASK),
        .OVERLAY_MASK (OMASK),
        .BG_IDX       (BG),
        .MIN_OVERLAP  (MINOV),
        .COOLDOWN_FR  (CDFR)
    ) dut (
        .board_clk (board_clk),
        .Reset     (Reset),
        .bus       (bus)
    );

    initial board_clk = 1'b0;
    always #5 board_clk = ~board_clk;

    typedef struct packed {
        logic        en;
        logic        fs;
        logic [15:0] lay;
        logic        fen;
        logic        ack;
    } rec_t;

    typedef enum {M_ARMED, M_FAILED, M_COOL} mode_t;

    rec_t       hist[$];
    int         m_cnt[4];
    logic [3:0] m_col;
    mode_t      m_mode;
    int         m_cd;
    logic       m_req;
    int         m_fails;
    logic [3:0] m_pix;
    logic       m_valid;

    int n_checks = 0;
    int n_fail   = 0;

    logic [17:0] obs;
    assign obs = {bus.pix_out, bus.pix_out_valid, bus.collision_vec, bus.fail_req, bus.fail_count};

    function automatic logic [3:0] lay_of(input logic [15:0] v, input int i);
        logic [15:0] t;
        t = v >> (4 * i);
        return t[3:0];
    endfunction

    function automatic logic [3:0] model_compose(input logic [15:0] v);
        logic [3:0] ovl;
        logic [3:0] base;
        bit         found;
        ovl = 4'h0; base = BG; found = 0;
        for (int i = 0; i < 4; i++) begin
            if (OMASK[i]) ovl = ovl | lay_of(v, i);
            else if (!found && lay_of(v, i) != 4'h0) begin
                base  = lay_of(v, i);
                found = 1;
            end
        end
        return base | ovl;
    endfunction

    function automatic logic [17:0] exp_vec();
        return {m_pix, m_valid, m_col, m_req, 8'(m_fails)};
    endfunction

    task automatic model_reset();
        hist.delete();
        for (int h = 0; h < 4; h++) m_cnt[h] = 0;
        m_col = 4'h0; m_mode = M_ARMED; m_cd = 0; m_req = 1'b0;
        m_fails = 0; m_pix = 4'h0; m_valid = 1'b0;
    endtask

    // One clock edge: the pixel seen by the mixer logic is the one presented a
    // cycle earlier; fail_enable / fail_ack act in the cycle they are presented.
    task automatic model_clock(input rec_t c);
        rec_t       s;
        logic [3:0] newcol;
        bit         bnd;
        bit         ov;
        s = (hist.size() != 0) ? hist[$] : '0;
        hist.push_back(c);
        if (hist.size() > 8) void'(hist.pop_front());
        m_valid = s.en;
        m_pix   = s.en ? model_compose(s.lay) : 4'h0;
        bnd     = s.fs;
        newcol  = m_col;
        for (int h = 0; h < 4; h++) begin
            ov = s.en && (lay_of(s.lay, P_IDX) != 0) && (lay_of(s.lay, h) != 0) && HMASK[h] && (h != P_IDX);
            if (bnd) begin
                newcol[h] = (m_cnt[h] >= MINOV);
                m_cnt[h]  = ov ? 1 : 0;
            end else if (ov) begin
                m_cnt[h] = (m_cnt[h] >= 255) ? 255 : m_cnt[h] + 1;
            end
        end
        m_col = newcol;
        case (m_mode)
            M_ARMED: if (bnd && newcol != 4'h0 && c.fen) begin
                m_mode = M_FAILED; m_req = 1'b1;
                if (m_fails < 255) m_fails++;
            end
            M_FAILED: if (c.ack) begin
                m_mode = M_COOL; m_req = 1'b0; m_cd = CDFR;
            end
            M_COOL: begin
                if (m_cd == 0) m_mode = M_ARMED;
                else if (bnd) m_cd--;
            end
            default: m_mode = M_ARMED;
        endcase
    endtask

    task automatic step(input logic en, input logic fs, input logic [15:0] lay,
                        input logic fen, input logic ack);
        rec_t c;
        @(negedge board_clk);
        bus.pix_en = en; bus.frame_start = fs; bus.layer_pix = lay;
        bus.fail_enable = fen; bus.fail_ack = ack;
        c.en = en; c.fs = fs; c.lay = lay; c.fen = fen; c.ack = ack;
        @(posedge board_clk);
        model_clock(c);
        #1;
    endtask

    task automatic apply_reset();
        bus.pix_en = 0; bus.frame_start = 0; bus.layer_pix = '0;
        bus.fail_enable = 0; bus.fail_ack = 0;
        #2 Reset = 1'b1;
        model_reset();
        #1;
    endtask

    task automatic release_reset();
        @(negedge board_clk);
        Reset = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        apply_reset();
        n_checks++;
        if (obs !== 18'h0) begin
            n_fail++; $display("FAIL reset_outputs: got %h expected 0", obs);
        end
        release_reset();
        step(0, 0, 16'h0, 1, 0);
        n_checks++;
        if (obs !== exp_vec()) begin
            n_fail++; $display("FAIL reset_idle: got %h expected %h", obs, exp_vec());
        end
    endtask

    task automatic test_composite();
        logic [15:0] vec [7];
        logic        en  [7];
        vec = '{16'h0500, 16'h0350, 16'h0000, 16'h4000, 16'h0010, 16'h0350, 16'h7302};
        en  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        apply_reset(); release_reset();
        for (int i = 0; i < 9; i++) begin
            step(i < 7 ? en[i] : 1'b0, 0, i < 7 ? vec[i] : 16'h0, 1, 0);
            if (i == 1) begin
                n_checks++;
                if (bus.pix_out !== 4'h5) begin
                    n_fail++; $display("FAIL comp_latency: pix_out=%h expected 5", bus.pix_out);
                end
            end
            n_checks++;
            if (obs !== exp_vec()) begin
                n_fail++; $display("FAIL comp_%0d: got %h expected %h", i, obs, exp_vec());
            end
        end
    endtask

    task automatic test_threshold();
        apply_reset(); release_reset();
        step(1, 1, PLY, 1, 0);
        repeat (3) step(1, 0, OVP, 1, 0);
        repeat (2) step(1, 0, PLY, 1, 0);
        step(1, 1, PLY, 1, 0);
        step(0, 0, 16'h0, 1, 0);
        n_checks++;
        if (bus.collision_vec !== 4'b0000 || bus.fail_req !== 1'b0) begin
            n_fail++; $display("FAIL thr_below: col=%b req=%b expected 0000/0", bus.collision_vec, bus.fail_req);
        end
        repeat (4) step(1, 0, OVP, 1, 0);
        step(1, 1, PLY, 1, 0);
        step(0, 0, 16'h0, 1, 0);
        n_checks++;
        if (bus.collision_vec !== 4'b0100 || bus.fail_req !== 1'b1 || bus.fail_count !== 8'd1) begin
            n_fail++; $display("FAIL thr_met: col=%b req=%b cnt=%0d expected 0100/1/1",
                               bus.collision_vec, bus.fail_req, bus.fail_count);
        end
        n_checks++;
        if (obs !== exp_vec()) begin
            n_fail++; $display("FAIL thr_model: got %h expected %h", obs, exp_vec());
        end
    endtask

    task automatic test_hold_cooldown();
        for (int i = 0; i < 1000; i++) begin
            step(0, (i % 100) == 0, 16'h0, 1, 0);
            n_checks++;
            if (obs !== exp_vec()) begin
                n_fail++; $display("FAIL hold_%0d: got %h expected %h", i, obs, exp_vec());
            end
        end
        n_checks++;
        if (bus.fail_req !== 1'b1 || bus.fail_count !== 8'd1) begin
            n_fail++; $display("FAIL hold_end: req=%b cnt=%0d expected 1/1", bus.fail_req, bus.fail_count);
        end
        step(0, 0, 16'h0, 1, 1);
        n_checks++;
        if (bus.fail_req !== 1'b0) begin
            n_fail++; $display("FAIL ack_drop: req=%b expected 0", bus.fail_req);
        end
        for (int f = 0; f < 3; f++) begin
            step(1, 1, OVP, 1, 0);
            repeat (4) step(1, 0, OVP, 1, 0);
            repeat (2) step(0, 0, 16'h0, 1, 0);
            n_checks++;
            if (bus.fail_req !== (f == 2)) begin
                n_fail++; $display("FAIL cooldown_frame%0d: req=%b expected %b", f, bus.fail_req, f == 2);
            end
        end
        n_checks++;
        if (obs !== exp_vec() || bus.fail_count !== 8'd2) begin
            n_fail++; $display("FAIL cooldown_end: got %h expected %h", obs, exp_vec());
        end
    endtask

    task automatic test_boundary_pixel();
        apply_reset(); release_reset();
        step(1, 1, PLY, 1, 0);
        repeat (3) step(1, 0, OVP, 1, 0);
        step(1, 0, PLY, 1, 0);
        step(1, 1, OVP, 1, 0);
        step(1, 0, OVP, 1, 0);
        n_checks++;
        if (bus.collision_vec !== 4'b0000) begin
            n_fail++; $display("FAIL bnd_old_frame: col=%b expected 0000", bus.collision_vec);
        end
        repeat (2) step(1, 0, OVP, 1, 0);
        step(1, 0, PLY, 1, 0);
        step(1, 1, PLY, 1, 0);
        step(0, 0, 16'h0, 1, 0);
        n_checks++;
        if (bus.collision_vec !== 4'b0100) begin
            n_fail++; $display("FAIL bnd_new_frame: col=%b expected 0100", bus.collision_vec);
        end
        n_checks++;
        if (obs !== exp_vec()) begin
            n_fail++; $display("FAIL bnd_model: got %h expected %h", obs, exp_vec());
        end
    endtask

    task automatic test_simultaneous();
        apply_reset(); release_reset();
        step(1, 1, PLY, 1, 0);
        repeat (4) step(1, 0, OVP, 1, 0);
        step(1, 1, PLY, 1, 0);
        step(0, 0, 16'h0, 1, 1);
        n_checks++;
        if (bus.fail_req !== 1'b1 || bus.fail_count !== 8'd1) begin
            n_fail++; $display("FAIL fail_vs_ack: req=%b cnt=%0d expected 1/1", bus.fail_req, bus.fail_count);
        end
        repeat (4) step(1, 0, OVP, 1, 0);
        step(1, 1, PLY, 1, 0);
        step(0, 0, 16'h0, 1, 1);
        n_checks++;
        if (bus.fail_req !== 1'b0 || bus.collision_vec !== 4'b0100 || bus.fail_count !== 8'd1) begin
            n_fail++; $display("FAIL fs_and_ack: req=%b col=%b cnt=%0d expected 0/0100/1",
                               bus.fail_req, bus.collision_vec, bus.fail_count);
        end
        step(1, 1, PLY, 1, 0);
        repeat (3) step(1, 0, OVP, 1, 0);
        apply_reset();
        n_checks++;
        if (obs !== 18'h0) begin
            n_fail++; $display("FAIL async_reset: got %h expected 0", obs);
        end
        release_reset();
        step(1, 0, OVP, 1, 0);
        step(1, 1, PLY, 1, 0);
        step(0, 0, 16'h0, 1, 0);
        n_checks++;
        if (bus.collision_vec !== 4'b0000 || obs !== exp_vec()) begin
            n_fail++; $display("FAIL reset_clears_cnt: got %h expected %h", obs, exp_vec());
        end
    endtask

    task automatic test_fail_disable();
        int runs [3];
        runs = '{10, 258, 300};
        apply_reset(); release_reset();
        step(1, 1, PLY, 0, 0);
        for (int r = 0; r < 3; r++) begin
            repeat (runs[r]) step(1, 0, OVP, 0, 0);
            step(1, 1, PLY, 0, 0);
            step(0, 0, 16'h0, 0, 0);
            n_checks++;
            if (bus.collision_vec !== 4'b0100 || bus.fail_req !== 1'b0) begin
                n_fail++; $display("FAIL disable_run%0d: col=%b req=%b expected 0100/0",
                                   runs[r], bus.collision_vec, bus.fail_req);
            end
        end
        n_checks++;
        if (obs !== exp_vec()) begin
            n_fail++; $display("FAIL disable_model: got %h expected %h", obs, exp_vec());
        end
    endtask

    task automatic test_random();
        logic [15:0] lay;
        apply_reset(); release_reset();
        for (int i = 0; i < 3000; i++) begin
            for (int k = 0; k < 4; k++)
                lay[k*4 +: 4] = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(1, 15)) : 4'h0;
            step($urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0, lay,
                 $urandom_range(0, 7) != 0, $urandom_range(0, 19) == 0);
            n_checks++;
            if (obs !== exp_vec()) begin
                n_fail++; $display("FAIL random_%0d: got %h expected %h", i, obs, exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_composite();
        test_threshold();
        test_hold_cooldown();
        test_boundary_pixel();
        test_simultaneous();
        test_fail_disable();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
